alu_req_arbiter: RTL

//   Shares the single combinational ALU between two requesters, e.g. the control unit and a debug/test port.

---
 rtl/alu_req_arbiter_if.sv | 41 ++++
 rtl/alu_req_arbiter.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter_if.sv
// rtl/alu_req_arbiter_if.sv - request/response/ALU bundle shared by the ALU arbiter and its neighbours
//
// Signals (two requesters, index i = requester i, requester 0 in the low slice):
//   req_valid/req_ready        request handshake, req_ready one-hot
//   req_oprn/req_op1/req_op2   packed per-requester opcode and operands
//   rsp_valid/rsp_ready        response handshake, at most one rsp_valid bit set
//   rsp_data/rsp_zero/rsp_err  response payload
//   alu_op1/alu_op2/alu_oprn   towards the combinational ALU
//   alu_out/alu_zero           from the combinational ALU
// Modports: slave = arbiter side, master = requester/ALU side.

interface alu_req_arbiter_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OPRN_WIDTH = 6
);
    logic [1:0]              req_valid;
    logic [1:0]              req_ready;
    logic [2*OPRN_WIDTH-1:0] req_oprn;
    logic [2*DATA_WIDTH-1:0] req_op1;
    logic [2*DATA_WIDTH-1:0] req_op2;
    logic [1:0]              rsp_valid;
    logic [1:0]              rsp_ready;
    logic [DATA_WIDTH-1:0]   rsp_data;
    logic                    rsp_zero;
    logic                    rsp_err;
    logic [DATA_WIDTH-1:0]   alu_op1;
    logic [DATA_WIDTH-1:0]   alu_op2;
    logic [OPRN_WIDTH-1:0]   alu_oprn;
    logic [DATA_WIDTH-1:0]   alu_out;
    logic                    alu_zero;

    modport slave (
        input  req_valid, req_oprn, req_op1, req_op2, rsp_ready, alu_out, alu_zero,
        output req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_op1, alu_op2, alu_oprn
    );

    modport master (
        output req_valid, req_oprn, req_op1, req_op2, rsp_ready, alu_out, alu_zero,
        input  req_ready, rsp_valid, rsp_data, rsp_zero, rsp_err, alu_op1, alu_op2, alu_oprn
    );
endinterface

// File: rtl/alu_req_arbiter.sv
// rtl/alu_req_arbiter.sv - round-robin sharing of one combinational ALU between two requesters
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   bus    slave modport of alu_req_arbiter_if (request, response and ALU signals)
//   busy   out  high whenever the arbiter is not idle
//
// Flow: IDLE accepts one request (round-robin), EXEC holds the latched operands on
// the ALU for a programmable settle time, RESP presents the sampled result until
// the owning requester takes it.

module alu_req_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int OPRN_WIDTH  = 6,
    parameter int EXEC_CYCLES = 1,
    parameter int MUL_EXTRA   = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    alu_req_arbiter_if.slave    bus,
    output logic                busy
);

    localparam int CNT_MAX = EXEC_CYCLES - 1 + MUL_EXTRA;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [OPRN_WIDTH-1:0] OPRN_MUL = OPRN_WIDTH'(3);
    localparam logic [OPRN_WIDTH-1:0] OPRN_MIN = OPRN_WIDTH'(1);
    localparam logic [OPRN_WIDTH-1:0] OPRN_MAX = OPRN_WIDTH'(9);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t                  state;
    state_t                  state_nxt;

    logic                    ptr;
    logic                    g_reg;
    logic                    err_r;
    logic [OPRN_WIDTH-1:0]   opr_r;
    logic [DATA_WIDTH-1:0]   op1_r;
    logic [DATA_WIDTH-1:0]   op2_r;
    logic [DATA_WIDTH-1:0]   rsp_data_r;
    logic                    rsp_zero_r;
    logic                    rsp_err_r;
    logic [CNT_W-1:0]        cnt;

    logic                    grant;
    logic                    grant_vld;
    logic                    accept;
    logic                    sample;
    logic [OPRN_WIDTH-1:0]   sel_oprn;
    logic [DATA_WIDTH-1:0]   sel_op1;
    logic [DATA_WIDTH-1:0]   sel_op2;
    logic                    sel_legal;
    logic [CNT_W-1:0]        cnt_load;

    // Pointer's requester wins if it is asking, otherwise the other one gets a turn.
    always_comb begin
        grant_vld = |bus.req_valid;
        grant     = ptr;
        if (!bus.req_valid[ptr]) begin
            grant = ~ptr;
        end
    end

    always_comb begin
        sel_oprn = grant ? bus.req_oprn[2*OPRN_WIDTH-1:OPRN_WIDTH] : bus.req_oprn[OPRN_WIDTH-1:0];
        sel_op1  = grant ? bus.req_op1[2*DATA_WIDTH-1:DATA_WIDTH]  : bus.req_op1[DATA_WIDTH-1:0];
        sel_op2  = grant ? bus.req_op2[2*DATA_WIDTH-1:DATA_WIDTH]  : bus.req_op2[DATA_WIDTH-1:0];
        sel_legal = (sel_oprn >= OPRN_MIN) && (sel_oprn <= OPRN_MAX);
        // Illegal opcodes still pass through EXEC for one cycle so the error
        // response appears with the same latency as a single-cycle operation.
        if (!sel_legal) begin
            cnt_load = '0;
        end else if (sel_oprn == OPRN_MUL) begin
            cnt_load = CNT_W'(EXEC_CYCLES - 1 + MUL_EXTRA);
        end else begin
            cnt_load = CNT_W'(EXEC_CYCLES - 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        sample    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (grant_vld) begin
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt == '0) begin
                    sample    = 1'b1;
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                if (bus.rsp_ready[g_reg]) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr        <= 1'b0;
            g_reg      <= 1'b0;
            err_r      <= 1'b0;
            opr_r      <= '0;
            op1_r      <= '0;
            op2_r      <= '0;
            cnt        <= '0;
            rsp_data_r <= '0;
            rsp_zero_r <= 1'b0;
            rsp_err_r  <= 1'b0;
        end else begin
            if (accept) begin
                opr_r <= sel_oprn;
                op1_r <= sel_op1;
                op2_r <= sel_op2;
                err_r <= ~sel_legal;
                g_reg <= grant;
                ptr   <= ~grant;
                cnt   <= cnt_load;
            end else if ((state == ST_EXEC) && (cnt != '0)) begin
                cnt <= cnt - CNT_W'(1);
            end

            if (sample) begin
                rsp_data_r <= err_r ? '0 : bus.alu_out;
                rsp_zero_r <= err_r ? 1'b0 : bus.alu_zero;
                rsp_err_r  <= err_r;
            end
        end
    end

    assign bus.req_ready = (state == ST_IDLE && grant_vld) ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_valid = (state == ST_RESP) ? (g_reg ? 2'b10 : 2'b01) : 2'b00;
    assign bus.rsp_data  = rsp_data_r;
    assign bus.rsp_zero  = rsp_zero_r;
    assign bus.rsp_err   = rsp_err_r;
    // Operands keep their last value; the opcode is parked at 0 unless a legal op is executing.
    assign bus.alu_op1   = op1_r;
    assign bus.alu_op2   = op2_r;
    assign bus.alu_oprn  = (state == ST_EXEC && !err_r) ? opr_r : '0;
    assign busy          = (state != ST_IDLE);

endmodule
